// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer
// Turns a stream of packet bytes into USB low/full-speed line signalling:
// SYNC (0x80), NRZI-encoded data with bit stuffing, then EOP (SE0 SE0 J).
// A one-entry holding register decouples the byte source from the shifter.
//
// Ports
//   clk       system clock, rising edge
//   n_rst     asynchronous active-low reset
//   tx_byte   byte to send, LSB first
//   tx_valid  tx_byte/tx_last are valid
//   tx_last   offered byte ends the packet
//   tx_ready  holding register empty (byte accepted on tx_valid && tx_ready)
//   d_plus    USB D+ line
//   d_minus   USB D- line
//   busy      packet in progress
//   tx_error  one-cycle pulse on underrun
module usb_tx_serializer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       busy,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_r;
  logic [7:0] clk_cnt_r;     // clock position inside the current bit period
  logic [2:0] bit_idx_r;     // index of the last real bit sent (SYNC/DATA), period count in EOP_SE0
  logic [2:0] ones_r;        // consecutive 1s on the wire
  logic       stuff_r;       // current bit period is a stuffed bit
  logic       eop_next_r;    // the stuffed bit in flight closes the packet
  logic [7:0] shift_r;       // byte currently on the wire
  logic       cur_last_r;    // shift_r is the final byte of the packet
  logic [7:0] hold_byte_r;
  logic       hold_last_r;
  logic       hold_full_r;

  logic       accept_s;
  logic       bit_end_s;
  logic       next_avail_s;
  logic [7:0] next_byte_s;
  logic       next_last_s;

  // Consecutive-ones count after sending bit b
  function automatic logic [2:0] ones_after(input logic b, input logic [2:0] cnt);
    if (b) begin
      return cnt + 3'd1;
    end else begin
      return 3'd0;
    end
  endfunction

  assign accept_s  = tx_valid && tx_ready;
  assign bit_end_s = (clk_cnt_r == BIT_LAST);

  // Next byte for a data handoff; a byte accepted on the handoff edge itself
  // goes straight to the shifter so it is not mistaken for an underrun.
  always_comb begin
    next_avail_s = hold_full_r || accept_s;
    if (hold_full_r) begin
      next_byte_s = hold_byte_r;
      next_last_s = hold_last_r;
    end else begin
      next_byte_s = tx_byte;
      next_last_s = tx_last;
    end
  end

  // Packet FSM, holding register, bit timing and registered line outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= IDLE;
      clk_cnt_r   <= 8'd0;
      bit_idx_r   <= 3'd0;
      ones_r      <= 3'd0;
      stuff_r     <= 1'b0;
      eop_next_r  <= 1'b0;
      shift_r     <= 8'd0;
      cur_last_r  <= 1'b0;
      hold_byte_r <= 8'd0;
      hold_last_r <= 1'b0;
      hold_full_r <= 1'b0;
      tx_ready    <= 1'b1;
      d_plus      <= 1'b1;
      d_minus     <= 1'b0;
      busy        <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_error <= 1'b0;

      // Later assignments in the case below override these on handoff edges.
      if (accept_s) begin
        hold_byte_r <= tx_byte;
        hold_last_r <= tx_last;
        hold_full_r <= 1'b1;
        tx_ready    <= 1'b0;
      end

      if (state_r != IDLE) begin
        clk_cnt_r <= bit_end_s ? 8'd0 : clk_cnt_r + 8'd1;
      end

      case (state_r)
        IDLE: begin
          if (accept_s || hold_full_r) begin
            // First SYNC bit is a 0: J -> K
            state_r    <= SYNC;
            busy       <= 1'b1;
            tx_ready   <= 1'b0;
            clk_cnt_r  <= 8'd0;
            bit_idx_r  <= 3'd0;
            ones_r     <= 3'd0;
            stuff_r    <= 1'b0;
            eop_next_r <= 1'b0;
            d_plus     <= 1'b0;
            d_minus    <= 1'b1;
          end else begin
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
          end
        end

        SYNC: begin
          if (bit_end_s) begin
            if (bit_idx_r == 3'd7) begin
              // SYNC done: hand the first byte to the shifter
              state_r     <= DATA;
              shift_r     <= hold_byte_r;
              cur_last_r  <= hold_last_r;
              hold_full_r <= 1'b0;
              tx_ready    <= 1'b1;
              bit_idx_r   <= 3'd0;
              ones_r      <= ones_after(hold_byte_r[0], ones_r);
              if (!hold_byte_r[0]) begin
                d_plus  <= ~d_plus;
                d_minus <= ~d_minus;
              end
            end else begin
              // SYNC bit 7 is the only 1
              bit_idx_r <= bit_idx_r + 3'd1;
              ones_r    <= ones_after(bit_idx_r == 3'd6, ones_r);
              if (bit_idx_r != 3'd6) begin
                d_plus  <= ~d_plus;
                d_minus <= ~d_minus;
              end
            end
          end
        end

        DATA: begin
          if (bit_end_s) begin
            if (stuff_r) begin
              stuff_r <= 1'b0;
              if (eop_next_r) begin
                state_r   <= EOP_SE0;
                tx_ready  <= 1'b0;
                bit_idx_r <= 3'd0;
                d_plus    <= 1'b0;
                d_minus   <= 1'b0;
              end else begin
                // bit_idx 7 here means the next byte was already loaded
                bit_idx_r <= bit_idx_r + 3'd1;
                ones_r    <= ones_after(shift_r[bit_idx_r + 3'd1], ones_r);
                if (!shift_r[bit_idx_r + 3'd1]) begin
                  d_plus  <= ~d_plus;
                  d_minus <= ~d_minus;
                end
              end
            end else if (bit_idx_r == 3'd7) begin
              if (!cur_last_r && !next_avail_s) begin
                // Underrun: close the packet immediately, no pending stuff
                tx_error  <= 1'b1;
                state_r   <= EOP_SE0;
                tx_ready  <= 1'b0;
                bit_idx_r <= 3'd0;
                d_plus    <= 1'b0;
                d_minus   <= 1'b0;
              end else begin
                if (!cur_last_r) begin
                  shift_r     <= next_byte_s;
                  cur_last_r  <= next_last_s;
                  hold_full_r <= 1'b0;
                  tx_ready    <= 1'b1;
                end
                if (ones_r == 3'd6) begin
                  stuff_r    <= 1'b1;
                  eop_next_r <= cur_last_r;
                  ones_r     <= 3'd0;
                  d_plus     <= ~d_plus;
                  d_minus    <= ~d_minus;
                end else if (cur_last_r) begin
                  state_r   <= EOP_SE0;
                  tx_ready  <= 1'b0;
                  bit_idx_r <= 3'd0;
                  d_plus    <= 1'b0;
                  d_minus   <= 1'b0;
                end else begin
                  bit_idx_r <= 3'd0;
                  ones_r    <= ones_after(next_byte_s[0], ones_r);
                  if (!next_byte_s[0]) begin
                    d_plus  <= ~d_plus;
                    d_minus <= ~d_minus;
                  end
                end
              end
            end else if (ones_r == 3'd6) begin
              stuff_r    <= 1'b1;
              eop_next_r <= 1'b0;
              ones_r     <= 3'd0;
              d_plus     <= ~d_plus;
              d_minus    <= ~d_minus;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              ones_r    <= ones_after(shift_r[bit_idx_r + 3'd1], ones_r);
              if (!shift_r[bit_idx_r + 3'd1]) begin
                d_plus  <= ~d_plus;
                d_minus <= ~d_minus;
              end
            end
          end
        end

        EOP_SE0: begin
          if (bit_end_s) begin
            if (bit_idx_r == 3'd1) begin
              state_r   <= EOP_J;
              bit_idx_r <= 3'd0;
              d_plus    <= 1'b1;
              d_minus   <= 1'b0;
            end else begin
              bit_idx_r <= 3'd1;
            end
          end
        end

        EOP_J: begin
          if (bit_end_s) begin
            // A byte caught on the final data edge waits here and starts the next packet
            state_r  <= IDLE;
            busy     <= 1'b0;
            tx_ready <= ~hold_full_r;
          end
        end

        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          tx_ready <= ~hold_full_r;
          d_plus   <= 1'b1;
          d_minus  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: directed vectors with
// hand-derived line sequences, reset and underrun sequences, and random
// packets compared against a bitstream-level reference model.
module tb_usb_tx_serializer;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus, d_minus, busy, tx_error;

  int checks = 0;
  int errors = 0;

  usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .d_plus(d_plus),
    .d_minus(d_minus), .busy(busy), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b [4];
    int         n;
    bit         last;
    string      data;   // expected data section of the line, one char per bit period
  } vec_t;

  vec_t tbl [5];

  // Current packet and its reference expectation
  logic [7:0] pkt [4];
  int         pkt_n;
  bit         pkt_last;
  string      exp_sym;
  int         hand_q [$];
  int         err_period;
  bit         m_lj;
  int         m_ones;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int line_char();
    if (d_plus && d_minus) return int'("X");
    if (d_plus) return int'("J");
    if (d_minus) return int'("K");
    return int'("0");
  endfunction

  // Reference model: append one wire bit (NRZI) and track the run of 1s
  function automatic void ref_bit(input bit b);
    if (!b) m_lj = !m_lj;
    m_ones = b ? m_ones + 1 : 0;
    exp_sym = {exp_sym, m_lj ? "J" : "K"};
  endfunction

  function automatic void ref_stuff();
    if (m_ones == 6) begin
      m_lj = !m_lj;
      m_ones = 0;
      exp_sym = {exp_sym, m_lj ? "J" : "K"};
    end
  endfunction

  // Whole-packet line sequence, handoff periods and underrun position
  function automatic void build_ref();
    exp_sym = "";
    hand_q.delete();
    err_period = -1;
    m_lj = 1'b1;
    m_ones = 0;
    for (int i = 0; i < 8; i++) ref_bit(i == 7);
    hand_q.push_back(7);
    for (int k = 0; k < pkt_n; k++) begin
      for (int i = 0; i < 8; i++) begin
        ref_bit(pkt[k][i]);
        if (i == 7 && k < pkt_n - 1) hand_q.push_back(exp_sym.len() - 1);
        if (i == 7 && k == pkt_n - 1 && !pkt_last) err_period = exp_sym.len();
        else ref_stuff();
      end
    end
    exp_sym = {exp_sym, "00J"};
  endfunction

  // Send pkt[] and check the line, tx_ready, busy and tx_error every cycle
  task automatic run_pkt(input string exp_line);
    int total;
    total = exp_line.len() * CPB;
    @(negedge clk);
    check("idle_ready", int'(tx_ready), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_line", line_char(), int'("J"));
    tx_byte  = pkt[0];
    tx_last  = (pkt_n == 1) ? pkt_last : 1'b0;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin : drv
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 1; k < pkt_n; k++) begin
          int w;
          tx_byte  = pkt[k];
          tx_last  = (k == pkt_n - 1) ? pkt_last : 1'b0;
          tx_valid = 1'b1;
          w = 0;
          while (!tx_ready && w < total) begin
            @(negedge clk);
            w++;
          end
          check("accept_in_time", int'(w < total), 1);
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
      begin : mon
        bit full;
        bit ready_e;
        bit is_hand;
        int p;
        full = 1'b1;
        for (int c = 0; c < total; c++) begin
          p = c / CPB;
          ready_e = !full && (p < exp_line.len() - 3);
          check($sformatf("line p%0d c%0d", p, c), line_char(), int'(exp_line[p]));
          check($sformatf("busy c%0d", c), int'(busy), 1);
          check($sformatf("tx_ready c%0d", c), int'(tx_ready), int'(ready_e));
          check($sformatf("tx_error c%0d", c), int'(tx_error),
                int'(p == err_period && (c % CPB) == 0));
          @(posedge clk);
          is_hand = 1'b0;
          foreach (hand_q[i]) if (hand_q[i] == p) is_hand = 1'b1;
          if ((c % CPB) == CPB - 1 && is_hand) full = 1'b0;
          else if (tx_valid && ready_e) full = 1'b1;
          #1;
        end
        check("end_busy", int'(busy), 0);
        check("end_line", line_char(), int'("J"));
        check("end_ready", int'(tx_ready), 1);
        check("end_error", int'(tx_error), 0);
      end
    join
  endtask

  task automatic run_vec(input int v);
    for (int i = 0; i < 4; i++) pkt[i] = tbl[v].b[i];
    pkt_n = tbl[v].n;
    pkt_last = tbl[v].last;
    build_ref();
    run_pkt({"KJKJKJKK", tbl[v].data, "00J"});
  endtask

  initial begin
    tbl[0] = '{'{8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b1, "JKJKJKJK"};
    tbl[1] = '{'{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 1'b1, "KKKKKJJJJ"};
    tbl[2] = '{'{8'h3F, 8'h00, 8'h00, 8'h00}, 1, 1'b1, "KKKKKJJKJ"};
    tbl[3] = '{'{8'hA5, 8'h3C, 8'h00, 8'h00}, 2, 1'b1, "KJJKJJKKJKKKKKJK"};
    tbl[4] = '{'{8'h12, 8'h00, 8'h00, 8'h00}, 1, 1'b0, "JJKJJKJK"};

    // Reset state
    #12;
    check("rst_line", line_char(), int'("J"));
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_error", int'(tx_error), 0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int v = 0; v < 5; v++) run_vec(v);

    // Reset in the middle of the data section abandons the packet
    @(negedge clk);
    tx_byte = 8'h55;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (11 * CPB) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(busy), 1);
    #1;
    n_rst = 1'b0;
    #1;
    check("mid_rst_line", line_char(), int'("J"));
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(tx_ready), 1);
    check("mid_rst_error", int'(tx_error), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    run_vec(0);

    // Random packets against the reference model
    for (int t = 0; t < 25; t++) begin
      pkt_n = $urandom_range(1, 3);
      pkt_last = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: pkt[i] = 8'hFF;
          1: pkt[i] = 8'(8'h7F << $urandom_range(0, 1));
          default: pkt[i] = 8'($urandom);
        endcase
      end
      build_ref();
      run_pkt(exp_sym);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
